mac_seq_ctrl: RTL and testbench
===============================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_CHUNKS, default 49, meaning 16-pixel chunks per neuron (784 pixels).
REQ-002 SHALL have parameter NUM_NEURONS, default 10, meaning neurons evaluated per inference.
REQ-003 SHALL have parameter ACC_W, default 26, meaning the accumulator and result width.
REQ-004 SHALL have ports clk, in, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have ports rst, in, 1, the reset; asynchronous and active-high.
REQ-006 SHALL have ports start, in, 1, a request to begin an inference, sampled only in IDLE.
REQ-007 SHALL have ports busy, out, 1, high in every state except IDLE.
REQ-008 SHALL have ports done, out, 1, a one-cycle pulse when an inference completes.
REQ-009 SHALL have ports pix_addr, out, clog2(NUM_CHUNKS), the pixel RAM chunk address.
REQ-010 SHALL have ports wgt_addr, out, clog2(NUM_CHUNKS*NUM_NEURONS), the weight RAM address.
REQ-011 SHALL have ports pix_data and wgt_data, in, 128 each, RAM read data with 1-cycle read latency.
REQ-012 SHALL have ports mac_pixels and mac_weights, out, 128 each, driven combinationally from pix_data and wgt_data.
REQ-013 SHALL have ports mac_sum, in, 20, the unsigned result from the 16-lane MAC; it is valid 2 cycles after its operands are presented.
REQ-014 SHALL have ports res_valid, out, 1; res_idx, out, 4; res_data, out, ACC_W; together these are the per-neuron result strobe, index and value.
REQ-015 SHALL have ports digit, out, 4; digit_max, out, ACC_W; together these are the argmax index and value, held until the next start.

Function
REQ-016 SHALL implement the FSM states IDLE, ISSUE, DRAIN, EMIT and FINISH.
REQ-017 SHALL make the IDLE->ISSUE transition on start=1; this clears the neuron and chunk counters, the argmax registers (digit=0, digit_max=0) and the accumulator.
REQ-018 SHALL, in ISSUE, issue one chunk per cycle with pix_addr=chunk and wgt_addr=neuron*NUM_CHUNKS+chunk, and assert the input bit of a 3-deep valid shift pipe.
REQ-019 SHALL take exactly NUM_CHUNKS cycles in ISSUE, with no gaps; after the last chunk (chunk=NUM_CHUNKS-1) the FSM goes to DRAIN.
REQ-020 SHALL, when the valid pipe output is 1, add mac_sum zero-extended into acc; this happens 3 cycles after the issue cycle.
REQ-021 SHALL keep acc unsigned modulo 2^ACC_W, with no saturation.
REQ-022 SHALL stay in DRAIN until the valid pipe is all-zero and the last accumulation has been done, then go to EMIT.
REQ-023 SHALL, in EMIT, pulse res_valid for one cycle with res_idx=neuron and res_data=acc.
REQ-024 SHALL, in EMIT, update the argmax: if acc > digit_max (strict), set digit=neuron and digit_max=acc, so ties keep the lower index.
REQ-025 SHALL, in EMIT, clear acc and chunk; if neuron<NUM_NEURONS-1 it increments neuron and goes to ISSUE, otherwise it goes to FINISH.
REQ-026 SHALL, in FINISH, pulse done for one cycle and go to IDLE; digit and digit_max stay stable from this cycle onward.
REQ-027 SHALL ignore start while busy=1, with no restart and no queueing.
REQ-028 SHALL make one inference take NUM_NEURONS*(NUM_CHUNKS+4)+2 cycles from the start sample to the done pulse, inclusive of done (532 cycles at the defaults).
REQ-029 SHALL hold pix_addr and wgt_addr at their last values outside ISSUE; outside EMIT res_data retains its last value.

Reset
REQ-030 SHALL, on rst=1 and regardless of clk, asynchronously force: state=IDLE, busy=0, done=0, res_valid=0, and zero for res_idx, res_data, digit, digit_max, pix_addr, wgt_addr, acc, all counters and the valid pipe.
REQ-031 SHALL, on a reset during an inference, discard in-flight MAC results: the cleared valid pipe blocks any accumulation after reset.
REQ-032 SHALL make the first start after rst deassertion get full service, with no stale acc contribution.

Verification
REQ-033 SHALL be verified for all-ones data: pix=0x01 in every byte, wgt=0x02 in every byte -> 10 res_valid pulses each with res_data=1568, digit=0, and done at cycle 532.
REQ-034 SHALL be verified for a distinct winner: neuron 7's weights are 0x03 and the rest 0x01, with pix=0x01 -> res_data[7]=2352, others 784, digit=7, digit_max=2352.
REQ-035 SHALL be verified for a tie: neurons 2 and 5 are equal maxima -> digit=2.
REQ-036 SHALL be verified for maximum values: all bytes 0xFF -> res_data=49*16*65025=50979600 for every neuron, with no wrap at ACC_W=26.
REQ-037 SHALL be verified for start while busy: a start pulse at cycle 100 -> no effect, and one done at 532.
REQ-038 SHALL be verified for reset mid-operation: rst during the DRAIN of neuron 3, then start -> all outputs are 0 after reset, and the next inference's results match REQ-033.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for a 16-lane MAC neuron evaluator.
//   For each of NUM_NEURONS neurons the block streams NUM_CHUNKS pixel/weight
//   chunks from two synchronous RAMs into an external pipelined MAC. It
//   accumulates the returned partial sums and emits one result per neuron.
//   It also tracks the running argmax, which becomes the classified digit.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin an inference (sampled only in IDLE)
//   busy, done          busy in every non-IDLE state; done is a 1-cycle completion pulse
//   pix_addr, wgt_addr  RAM chunk addresses (1-cycle read latency)
//   pix_data, wgt_data  RAM read data
//   mac_pixels/weights  MAC operands, passed straight through from the RAM data
//   mac_sum             MAC result, valid 2 cycles after the operands are presented
//   res_valid/idx/data  per-neuron result strobe
//   digit, digit_max    argmax index and value
//   dbg_state           current FSM state, for observation only
// Handshake: there is no back-pressure. The MAC result is qualified only by the
//   internal 3-deep valid pipe, and res_valid is a single-cycle strobe that the
//   consumer must take in that cycle.
module mac_seq_ctrl #(
  parameter int NUM_CHUNKS  = 49,
  parameter int NUM_NEURONS = 10,
  parameter int ACC_W       = 26,
  localparam int PIX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
  localparam int WGT_W = (NUM_CHUNKS * NUM_NEURONS > 1) ? $clog2(NUM_CHUNKS * NUM_NEURONS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [PIX_W-1:0]  pix_addr,
  output logic [WGT_W-1:0]  wgt_addr,
  input  logic [127:0]      pix_data,
  input  logic [127:0]      wgt_data,
  output logic [127:0]      mac_pixels,
  output logic [127:0]      mac_weights,
  input  logic [19:0]       mac_sum,
  output logic              res_valid,
  output logic [3:0]        res_idx,
  output logic [ACC_W-1:0]  res_data,
  output logic [3:0]        digit,
  output logic [ACC_W-1:0]  digit_max,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_DRAIN  = 3'd2,
    S_EMIT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [PIX_W-1:0] r_chunk;
  logic [3:0]       r_neuron;
  logic [ACC_W-1:0] r_acc;
  logic [2:0]       r_vpipe;     // [0] = issue stage, [2] = mac_sum valid
  logic [PIX_W-1:0] r_pix_addr;
  logic [WGT_W-1:0] r_wgt_addr;
  logic [ACC_W-1:0] r_res_data;
  logic [3:0]       r_digit;
  logic [ACC_W-1:0] r_digit_max;
  logic             w_last_chunk;
  logic             w_last_neuron;
  logic             w_busy;
  logic             w_done;
  logic             w_res_valid;

  assign w_last_chunk  = (r_chunk == PIX_W'(NUM_CHUNKS - 1));
  assign w_last_neuron = (r_neuron == 4'(NUM_NEURONS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_res_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_next_state = S_ISSUE;
      end
      S_ISSUE: if (w_last_chunk) w_next_state = S_DRAIN;
      // Leave once nothing is left behind the output stage; the final
      // accumulation happens on the same edge that enters EMIT.
      S_DRAIN: if (r_vpipe[1:0] == 2'b00) w_next_state = S_EMIT;
      S_EMIT: begin
        w_res_valid  = 1'b1;
        w_next_state = w_last_neuron ? S_FINISH : S_ISSUE;
      end
      S_FINISH: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chunk     <= '0;
      r_neuron    <= '0;
      r_acc       <= '0;
      r_vpipe     <= '0;
      r_pix_addr  <= '0;
      r_wgt_addr  <= '0;
      r_res_data  <= '0;
      r_digit     <= '0;
      r_digit_max <= '0;
    end else begin
      r_vpipe <= {r_vpipe[1:0], (r_state == S_ISSUE)};
      if (r_vpipe[2]) r_acc <= r_acc + ACC_W'(mac_sum);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_chunk     <= '0;
            r_neuron    <= '0;
            r_acc       <= '0;
            r_pix_addr  <= '0;
            r_wgt_addr  <= '0;
            r_digit     <= '0;
            r_digit_max <= '0;
          end
        end
        S_ISSUE: begin
          // Addresses are loaded one edge ahead so they are valid throughout
          // each issue cycle and simply freeze once issuing stops.
          if (!w_last_chunk) begin
            r_chunk    <= r_chunk + PIX_W'(1);
            r_pix_addr <= r_chunk + PIX_W'(1);
            r_wgt_addr <= r_wgt_addr + WGT_W'(1);
          end
        end
        S_EMIT: begin
          r_res_data <= r_acc;
          if (r_acc > r_digit_max) begin
            r_digit     <= r_neuron;
            r_digit_max <= r_acc;
          end
          r_acc   <= '0;
          r_chunk <= '0;
          if (!w_last_neuron) begin
            r_neuron   <= r_neuron + 4'd1;
            r_pix_addr <= '0;
            // Weight rows are contiguous, so the next neuron starts one past
            // the last chunk of this one.
            r_wgt_addr <= r_wgt_addr + WGT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = w_busy;
  assign done        = w_done;
  assign res_valid   = w_res_valid;
  assign res_idx     = r_neuron;
  assign res_data    = (r_state == S_EMIT) ? r_acc : r_res_data;
  assign digit       = r_digit;
  assign digit_max   = r_digit_max;
  assign pix_addr    = r_pix_addr;
  assign wgt_addr    = r_wgt_addr;
  assign mac_pixels  = pix_data;
  assign mac_weights = wgt_data;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;
  localparam int NC = 49;
  localparam int NN = 10;
  localparam int W  = 26;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, res_valid;
  logic [5:0]    pix_addr;
  logic [8:0]    wgt_addr;
  logic [127:0]  pix_data = '0, wgt_data = '0;
  logic [127:0]  mac_pixels, mac_weights;
  logic [19:0]   mac_sum;
  logic [3:0]    res_idx, digit;
  logic [W-1:0]  res_data, digit_max;
  logic [2:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  mac_seq_ctrl #(.NUM_CHUNKS(NC), .NUM_NEURONS(NN), .ACC_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pix_addr(pix_addr), .wgt_addr(wgt_addr),
    .pix_data(pix_data), .wgt_data(wgt_data),
    .mac_pixels(mac_pixels), .mac_weights(mac_weights), .mac_sum(mac_sum),
    .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
    .digit(digit), .digit_max(digit_max), .dbg_state(dbg_state)
  );

  // RAM models (1-cycle read latency) and 2-cycle MAC model
  logic [127:0] pix_mem [NC];
  logic [127:0] wgt_mem [NC*NN];
  logic [19:0]  m1 = '0, m2 = '0;

  function automatic logic [19:0] dot16(input logic [127:0] a, input logic [127:0] b);
    logic [19:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + 20'(a[i*8 +: 8]) * 20'(b[i*8 +: 8]);
    return s;
  endfunction

  always @(posedge clk) begin
    pix_data <= pix_mem[pix_addr];
    wgt_data <= wgt_mem[wgt_addr];
    m1 <= dot16(mac_pixels, mac_weights);
    m2 <= m1;
  end
  assign mac_sum = m2;

  // result monitor
  int           res_cnt, done_cnt;
  logic [W-1:0] res_got [NN];
  always @(negedge clk) begin
    if (res_valid) begin
      res_got[res_idx] = res_data;
      res_cnt++;
    end
    if (done) done_cnt++;
  end

  // driver tasks
  task automatic load(input logic [7:0] pb, input logic [7:0] w_def,
                      input logic [7:0] w_hi, input logic [NN-1:0] hi_mask);
    for (int c = 0; c < NC; c++) pix_mem[c] = {16{pb}};
    for (int n = 0; n < NN; n++)
      for (int c = 0; c < NC; c++)
        wgt_mem[n*NC + c] = {16{hi_mask[n] ? w_hi : w_def}};
  endtask

  // Starts an inference and returns the cycle number of done (start sample =
  // cycle 1), or -1 on timeout. busy_start_at re-asserts start in that cycle.
  task automatic run_inf(input int busy_start_at, output int cyc_done);
    int cyc;
    res_cnt = 0;
    done_cnt = 0;
    for (int n = 0; n < NN; n++) res_got[n] = 'x;
    @(negedge clk);
    start = 1'b1;
    cyc = 1;
    cyc_done = -1;
    while (cyc < 700) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == busy_start_at) start = 1'b1;
      if (done) begin
        cyc_done = cyc;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, res_valid, res_idx, res_data, digit, digit_max, pix_addr, wgt_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b rv=%b idx=%0d rd=%0d dig=%0d max=%0d pa=%0d wa=%0d, required all 0",
               busy, done, res_valid, res_idx, res_data, digit, digit_max, pix_addr, wgt_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_addresses;
    int cyc;
    load(8'h01, 8'h02, 8'h02, '0);
    @(negedge clk);
    start = 1'b1;
    cyc = 1;
    while (cyc < 700) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == 2) begin
        checks++;
        if (!(busy === 1'b1 && pix_addr === 6'd0 && wgt_addr === 9'd0)) begin
          failures++;
          $display("FAIL addr_first: busy=%b pa=%0d wa=%0d, required 1/0/0", busy, pix_addr, wgt_addr);
        end
      end
      if (cyc == 50) begin
        checks++;
        if (!(pix_addr === 6'd48 && wgt_addr === 9'd48)) begin
          failures++;
          $display("FAIL addr_last_chunk: pa=%0d wa=%0d, required 48/48", pix_addr, wgt_addr);
        end
      end
      if (cyc == 52) begin
        checks++;
        if (!(pix_addr === 6'd48 && wgt_addr === 9'd48 && res_valid === 1'b0)) begin
          failures++;
          $display("FAIL addr_hold_drain: pa=%0d wa=%0d rv=%b, required 48/48/0", pix_addr, wgt_addr, res_valid);
        end
      end
      if (cyc == 54) begin
        checks++;
        if (!(res_valid === 1'b1 && res_idx === 4'd0 && res_data === 26'd1568)) begin
          failures++;
          $display("FAIL emit_n0: rv=%b idx=%0d rd=%0d, required 1/0/1568", res_valid, res_idx, res_data);
        end
      end
      if (cyc == 56) begin
        checks++;
        if (!(pix_addr === 6'd1 && wgt_addr === 9'd50)) begin
          failures++;
          $display("FAIL addr_neuron1: pa=%0d wa=%0d, required 1/50", pix_addr, wgt_addr);
        end
      end
      if (done) break;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_all_ones;
    int cd;
    load(8'h01, 8'h02, 8'h02, '0);
    run_inf(0, cd);
    checks++;
    if (cd !== 532) begin failures++; $display("FAIL ones_done_cycle: got %0d, required 532", cd); end
    checks++;
    if (res_cnt !== NN || done_cnt !== 1) begin
      failures++;
      $display("FAIL ones_counts: res=%0d done=%0d, required 10/1", res_cnt, done_cnt);
    end
    for (int n = 0; n < NN; n++) begin
      checks++;
      if (res_got[n] !== 26'd1568) begin
        failures++;
        $display("FAIL ones_res%0d: got %0d, required 1568", n, res_got[n]);
      end
    end
    checks++;
    if (!(digit === 4'd0 && digit_max === 26'd1568 && busy === 1'b0 && res_data === 26'd1568)) begin
      failures++;
      $display("FAIL ones_final: dig=%0d max=%0d busy=%b rd=%0d, required 0/1568/0/1568",
               digit, digit_max, busy, res_data);
    end
  endtask

  task automatic test_winner;
    int cd;
    load(8'h01, 8'h01, 8'h03, 10'b00_1000_0000);
    run_inf(0, cd);
    for (int n = 0; n < NN; n++) begin
      checks++;
      if (res_got[n] !== ((n == 7) ? 26'd2352 : 26'd784)) begin
        failures++;
        $display("FAIL winner_res%0d: got %0d, required %0d", n, res_got[n], (n == 7) ? 2352 : 784);
      end
    end
    checks++;
    if (!(digit === 4'd7 && digit_max === 26'd2352)) begin
      failures++;
      $display("FAIL winner_argmax: dig=%0d max=%0d, required 7/2352", digit, digit_max);
    end
  endtask

  task automatic test_tie;
    int cd;
    load(8'h01, 8'h01, 8'h02, 10'b00_0010_0100);
    run_inf(0, cd);
    checks++;
    if (!(res_got[2] === 26'd1568 && res_got[5] === 26'd1568 && res_got[9] === 26'd784)) begin
      failures++;
      $display("FAIL tie_res: r2=%0d r5=%0d r9=%0d, required 1568/1568/784", res_got[2], res_got[5], res_got[9]);
    end
    checks++;
    if (!(digit === 4'd2 && digit_max === 26'd1568)) begin
      failures++;
      $display("FAIL tie_argmax: dig=%0d max=%0d, required 2/1568", digit, digit_max);
    end
  endtask

  task automatic test_max;
    int cd;
    load(8'hFF, 8'hFF, 8'hFF, '0);
    run_inf(0, cd);
    for (int n = 0; n < NN; n++) begin
      checks++;
      if (res_got[n] !== 26'd50979600) begin
        failures++;
        $display("FAIL max_res%0d: got %0d, required 50979600", n, res_got[n]);
      end
    end
    checks++;
    if (!(digit === 4'd0 && digit_max === 26'd50979600)) begin
      failures++;
      $display("FAIL max_argmax: dig=%0d max=%0d, required 0/50979600", digit, digit_max);
    end
  endtask

  task automatic test_start_busy;
    int cd;
    load(8'h01, 8'h02, 8'h02, '0);
    run_inf(100, cd);
    checks++;
    if (cd !== 532 || done_cnt !== 1 || res_cnt !== NN) begin
      failures++;
      $display("FAIL busy_start: done_cyc=%0d done=%0d res=%0d, required 532/1/10", cd, done_cnt, res_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    int cd;
    load(8'h01, 8'h02, 8'h02, '0);
    @(negedge clk);
    start = 1'b1;
    cyc = 1;
    // neuron 3 drains in cycles 210..212
    while (cyc < 211) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, res_valid, res_idx, res_data, digit, digit_max, pix_addr, wgt_addr} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: busy=%b idx=%0d rd=%0d dig=%0d max=%0d pa=%0d wa=%0d, required all 0",
               busy, res_idx, res_data, digit, digit_max, pix_addr, wgt_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_inf(0, cd);
    checks++;
    if (cd !== 532 || res_cnt !== NN) begin
      failures++;
      $display("FAIL midreset_rerun: done_cyc=%0d res=%0d, required 532/10", cd, res_cnt);
    end
    for (int n = 0; n < NN; n++) begin
      checks++;
      if (res_got[n] !== 26'd1568) begin
        failures++;
        $display("FAIL midreset_res%0d: got %0d, required 1568", n, res_got[n]);
      end
    end
    checks++;
    if (!(digit === 4'd0 && digit_max === 26'd1568)) begin
      failures++;
      $display("FAIL midreset_argmax: dig=%0d max=%0d, required 0/1568", digit, digit_max);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    res_cnt = 0;
    done_cnt = 0;
    load(8'h00, 8'h00, 8'h00, '0);
    test_reset;
    test_addresses;
    test_all_ones;
    test_winner;
    test_tie;
    test_max;
    test_start_busy;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
